// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that serialises read/write commands onto a
// single-port SRAM. One transaction at a time: IDLE -> ACCESS -> RESP -> IDLE.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [WIDTH-1:0]      wdata0_i,
  input  logic [WIDTH-1:0]      wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  busy_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic [1:0]            state_o
);

  // Handshake: a requester holds req/we/addr/wdata stable until its one-cycle
  // ack; on the edge ending the ack it drops req or presents the next command.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                state_q;
  logic                  last_q;
  logic                  gnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;
  logic                  ack0_q;
  logic                  ack1_q;
  logic                  wr_en_q;
  logic                  rd_en_q;

  logic                  sel;
  logic                  sel_we;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  assign sel    = (req0_i && req1_i) ? ~last_q : req1_i;
  assign sel_we = sel ? we1_i : we0_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0_i || req1_i) begin
            gnt_q   <= sel;
            last_q  <= sel;
            we_q    <= sel_we;
            addr_q  <= sel ? addr1_i : addr0_i;
            wdata_q <= sel ? wdata1_i : wdata0_i;
            wr_en_q <= sel_we;
            rd_en_q <= ~sel_we;
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          ack0_q  <= ~gnt_q;
          ack1_q  <= gnt_q;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wr_en_o = wr_en_q;
  assign mem_rd_en_o = rd_en_q;
  assign busy_o      = (state_q != S_IDLE);
  assign state_o     = state_q;
  // Memory read data is registered at the end of ACCESS, so it is valid all of RESP.
  assign rdata_o     = (state_q == S_RESP && !we_q) ? mem_rdata_i : '0;

endmodule
